updown_counter_param: RTL
=========================

# updown_counter_param

Parametrised up/down counter with programmable step, runtime lower/upper bounds, and a selectable wrap or saturate policy at the bounds. It reports a one-cycle terminal-count pulse plus sticky overflow/underflow flags. It is the generalised successor of the team's fixed 8-bit load/up/down counter and is intended as the common counter primitive for timers, address generators and event counters in the design.

## Interface
Parameters:
- WIDTH, 8, counter/data width in bits (≥2)
- RESET_VAL, 0, value of y after reset (WIDTH bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high; clock clk
- en  in  1  count enable
- up  in  1  direction: 1 = count up, 0 = count down
- step  in  WIDTH  increment/decrement magnitude per enabled cycle
- mode  in  1  bound policy: 0 = wrap, 1 = saturate
- lo  in  WIDTH  lower bound (unsigned)
- hi  in  WIDTH  upper bound (unsigned)
- load  in  1  synchronous load strobe
- loadin  in  WIDTH  load value
- clr_flags  in  1  clears ovf/udf
- y  out  WIDTH  counter value (registered)
- tc  out  1  terminal-count pulse (registered)
- ovf  out  1  sticky overflow flag (registered)
- udf  out  1  sticky underflow flag (registered)

## Operation
- Priority per edge: rst > load > en. With none active, y holds.
- rst: y = RESET_VAL, tc = 0, ovf = 0, udf = 0.
- load: y = loadin unmodified; no bounds check, no clamp; tc = 0; ovf/udf unaffected except by clr_flags.
- Counting (en=1, no load). All arithmetic is unsigned, WIDTH+1 bits:
  - Up: sum = y + step. An overflow event occurs if sum > hi (carry out counts as > hi).
  - Down: event-free if y ≥ step and y − step ≥ lo. Otherwise an underflow event occurs (borrow counts as < lo).
  - No event: y = sum (up) or y − step (down).
  - Overflow event: wrap mode y = lo; saturate mode y = hi. The remainder is discarded.
  - Underflow event: wrap mode y = hi; saturate mode y = lo.
  - Exactly reaching hi or lo is not an event.
- step = 0: y unchanged, and no event is possible.
- y outside [lo,hi] (bounds changed at runtime): apply the same rules. For example, y > hi counting up produces an overflow event immediately.
- lo > hi: the rules apply literally with no special handling. Behaviour is defined but not meaningful, and callers must not rely on it.
- Saturate mode held at a bound and still counting outward: an event occurs every enabled cycle.
- tc is 1 in the cycle after any overflow or underflow event edge, else 0.
- ovf/udf are set by their event and cleared by clr_flags. If set and clear occur in the same cycle, set wins. rst clears both.

## Timing
- Single-cycle: y, tc, ovf and udf reflect the inputs sampled at the same rising edge. Counting and load latency is 1 cycle.
- No combinational path from inputs to outputs.
- tc width is exactly one cycle per event. Back-to-back events give tc held high continuously.
- rst mid-count takes effect at the next edge regardless of en/load/clr_flags.
- No handshake: en, load, step, bounds and mode may change every cycle and are sampled only at the edge.

## Test plan
All scenarios use WIDTH=8, RESET_VAL=0.
- Reset priority: rst=1, load=1, loadin=0x55, en=1 → y=0, tc=0, ovf=0, udf=0. Then rst=0, load=1 → y=0x55 next edge.
- Wrap up: lo=10, hi=20, step=3, mode=0, load 18, then en=1, up=1 → y=10 with tc=1 and ovf=1 for one cycle. Next edge y=13, tc=0, ovf remains 1.
- Saturate down: lo=5, hi=200, step=4, mode=1, load 7, en=1, up=0 → y=5, tc=1, udf=1. Next edge y=5, tc=1 again.
- Full range: lo=0, hi=255, step=1, mode=0:
  - Up from 255 → y=0, ovf=1.
  - Down from 0 → y=255, udf=1.
  - Up with step=255 from 1 → carry, y=0.
- Holds and exact bounds:
  - en=0 → y unchanged.
  - step=0 with en=1 → y unchanged, tc=0.
  - lo=10, hi=20, y=17, step=3, up → y=20, tc=0, ovf=0.
- Flags and priority:
  - clr_flags together with a new overflow event → ovf stays 1.
  - clr_flags alone → ovf=0, udf=0 next edge.
  - load with en=1 → y=loadin, tc=0.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable step, runtime bounds, and
// wrap/saturate bound policy; flags a one-cycle tc pulse and sticky ovf/udf.
module updown_counter_param #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] loadin,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             counting;
  logic             step_nz;
  logic             ovf_evt;
  logic             udf_evt;

  // Both directions are computed one bit wider so carry/borrow fall out naturally.
  assign sum      = {1'b0, y_q} + {1'b0, step};
  assign diff     = {1'b0, y_q} - {1'b0, step};
  assign counting = en && !load;
  assign step_nz  = (step != '0);

  assign ovf_evt = counting && step_nz && up && (sum > {1'b0, hi});
  assign udf_evt = counting && step_nz && !up &&
                   !((y_q >= step) && (diff[WIDTH-1:0] >= lo));

  always_comb begin
    y_d = y_q;
    if (load) begin
      y_d = loadin;
    end else if (ovf_evt) begin
      y_d = mode ? hi : lo;
    end else if (udf_evt) begin
      y_d = mode ? lo : hi;
    end else if (counting) begin
      y_d = up ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  // Setting an event flag overrides a simultaneous clear.
  always_comb begin
    tc_d  = ovf_evt || udf_evt;
    ovf_d = (ovf_q && !clr_flags) || ovf_evt;
    udf_d = (udf_q && !clr_flags) || udf_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= RESET_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign y   = y_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule
